// File: rtl/multiplier_pkg.sv
// Shared types for the shift-add multiplier: iteration count, controller states and the
// one-hot datapath command bundle.
package multiplier_pkg;

    localparam int unsigned N_BITS = 8;
    localparam int unsigned CNT_W  = $clog2(N_BITS);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ADD,
        SHIFT,
        HOLD
    } mult_state_e;

    typedef struct packed {
        logic clr_ld;
        logic clear_xa;
        logic add;
        logic sub;
        logic shift;
    } mult_cmd_t;

endpackage

// File: rtl/mult_step_counter.sv
// Iteration counter for the multiply loop; saturates at N_BITS-1 and flags the last step.
module mult_step_counter #(
    parameter int unsigned N_BITS = 8,
    parameter int unsigned CNT_W  = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_last) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_last = (r_count == CNT_W'(N_BITS - 1));

endmodule

// File: rtl/multiplier_control.sv
// Sequencer for the 8-bit shift-add multiplier datapath.
// Build option MULT_SKIP_ZERO_ADD_EN: iterations whose multiplier bit is 0 take one cycle.
module multiplier_control
    import multiplier_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic ClearXA,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    mult_state_e r_state;
    mult_cmd_t   w_cmd;
    logic        w_last;
    logic        w_cnt_clr;
    logic        w_cnt_inc;
    logic        w_skip;

`ifdef MULT_SKIP_ZERO_ADD_EN
    // An ADD cycle with M=0 has nothing to add, so it shifts immediately instead.
    assign w_skip = (r_state == ADD) && !M;
`else
    assign w_skip = 1'b0;
`endif

    assign w_cnt_clr = (r_state == CLR);
    assign w_cnt_inc = (r_state == SHIFT) || w_skip;

    mult_step_counter #(
        .N_BITS (N_BITS),
        .CNT_W  (CNT_W)
    ) u_step_counter (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_last  (w_last)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (Run) r_state <= CLR;
                CLR:     r_state <= ADD;
                ADD:     begin
                    if (w_skip) r_state <= w_last ? HOLD : ADD;
                    else        r_state <= SHIFT;
                end
                SHIFT:   r_state <= w_last ? HOLD : ADD;
                HOLD:    if (!Run) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sub on the last iteration corrects for the multiplier's sign bit.
    always_comb begin
        w_cmd = '0;
        case (r_state)
            IDLE:  w_cmd.clr_ld   = ClearA_LoadB && !Run;
            CLR:   w_cmd.clear_xa = 1'b1;
            ADD:   begin
                w_cmd.add   = M && !w_last;
                w_cmd.sub   = M && w_last;
                w_cmd.shift = w_skip;
            end
            SHIFT: w_cmd.shift    = 1'b1;
            default: ;
        endcase
    end

    assign Clr_Ld  = w_cmd.clr_ld;
    assign ClearXA = w_cmd.clear_xa;
    assign Add     = w_cmd.add;
    assign Sub     = w_cmd.sub;
    assign Shift   = w_cmd.shift;
    assign Busy    = (r_state == CLR) || (r_state == ADD) || (r_state == SHIFT);
    assign Done    = (r_state == HOLD);

endmodule
